// File: rtl/wb_regfile_unit_if.sv
// MEM/WB write-back bundle plus ID read ports and commit/retire outputs.
interface wb_regfile_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              wb_valid;
    logic [DATA_W-1:0] WB_aluresult;
    logic [DATA_W-1:0] WB_memread;
    logic [ADDR_W-1:0] WB_writereg;
    logic              WB_memtoreg;
    logic              WB_regwrite;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic              last_we;
    logic [ADDR_W-1:0] last_reg;
    logic [DATA_W-1:0] last_data;
    logic [CNT_W-1:0]  retire_count;

    modport master (
        output wb_valid, WB_aluresult, WB_memread,
        output WB_writereg, WB_memtoreg, WB_regwrite,
        output rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data,
        input  last_we, last_reg, last_data, retire_count
    );

    modport slave (
        input  wb_valid, WB_aluresult, WB_memread,
        input  WB_writereg, WB_memtoreg, WB_regwrite,
        input  rs_addr, rt_addr,
        output rs_data, rt_data, wb_data,
        output last_we, last_reg, last_data, retire_count
    );
endinterface

// File: rtl/wb_regfile_unit.sv
// Write-back stage: result select, 32-entry register file, commit record.
// Define WB_BYPASS_EN for same-cycle write-through on the read ports.
module wb_regfile_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic clk,
    input  logic rst_n,
    wb_regfile_unit_if.slave bus
);
    localparam int N = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [N];
    logic [DATA_W-1:0] sel;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic              commit;
    logic              lwe;
    logic [ADDR_W-1:0] lreg;
    logic [DATA_W-1:0] ldata;
    logic [CNT_W-1:0]  cnt;

    assign sel    = bus.WB_memtoreg ? bus.WB_memread : bus.WB_aluresult;
    assign commit = bus.wb_valid & bus.WB_regwrite
                  & (bus.WB_writereg != '0);

    always_comb begin
        rs = regs[bus.rs_addr];
        rt = regs[bus.rt_addr];
`ifdef WB_BYPASS_EN
        if (commit && bus.rs_addr == bus.WB_writereg) rs = sel;
        if (commit && bus.rt_addr == bus.WB_writereg) rt = sel;
`endif
        // r0 is hardwired and nothing is readable while in reset
        if (!rst_n || bus.rs_addr == '0) rs = '0;
        if (!rst_n || bus.rt_addr == '0) rt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
            lwe   <= 1'b0;
            lreg  <= '0;
            ldata <= '0;
            cnt   <= '0;
        end else begin
            if (commit) regs[bus.WB_writereg] <= sel;
            lwe   <= commit;
            lreg  <= bus.WB_writereg;
            ldata <= sel;
            if (bus.wb_valid) cnt <= cnt + 1'b1;
        end
    end

    assign bus.wb_data      = sel;
    assign bus.rs_data      = rs;
    assign bus.rt_data      = rt;
    assign bus.last_we      = lwe;
    assign bus.last_reg     = lreg;
    assign bus.last_data    = ldata;
    assign bus.retire_count = cnt;
endmodule

// File: doc/wb_regfile_unit.md
Name: wb_regfile_unit

Overview:
- Consumer end of the MEM/WB pipeline register; realises the write-back stage.
- Selects the write-back value from the ALU result or memory read data.
- Commits that value into a 32-entry architectural register file, which it owns.
- Serves the two ID-stage read ports.
- Registers a one-cycle "last commit" record for the forwarding logic, and counts retired instructions.

Parameters:
DATA_W, 32, width of datapath and register entries
ADDR_W, 5, register index width (2**ADDR_W entries)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
wb_valid  input  1  WB slot holds a real instruction (0 = bubble)
WB_aluresult  input  DATA_W  ALU result from MEM/WB
WB_memread  input  DATA_W  load data from MEM/WB
WB_writereg  input  ADDR_W  destination register index
WB_memtoreg  input  1  1 = write load data, 0 = write ALU result
WB_regwrite  input  1  instruction writes a register
rs_addr  input  ADDR_W  read port A index
rt_addr  input  ADDR_W  read port B index
rs_data  output  DATA_W  read port A data (combinational)
rt_data  output  DATA_W  read port B data (combinational)
wb_data  output  DATA_W  selected write-back value (combinational)
last_we  output  1  registered: a commit happened on the previous edge
last_reg  output  ADDR_W  registered: index of that commit
last_data  output  DATA_W  registered: value of that commit
retire_count  output  CNT_W  valid instructions retired since reset

Behaviour:
- Clock and reset are decided: one clock, port `clk`. Reset is asynchronous and active-low, port `rst_n`.
- Reset (rst_n=0, asynchronous, any time including mid-commit):
  - all register entries = 0; last_we = 0, last_reg = 0, last_data = 0; retire_count = 0.
  - Any write on the same edge as an asserted reset is discarded.
  - Reads during reset return 0.
- wb_data = WB_memtoreg ? WB_memread : WB_aluresult.
  - Purely combinational; driven even when wb_valid = 0.
- Commit condition: commit = wb_valid & WB_regwrite & (WB_writereg != 0).
- On each rising clk with rst_n = 1:
  - If commit: regs[WB_writereg] <= wb_data.
  - last_we <= commit; last_reg <= WB_writereg; last_data <= wb_data.
    - Pipelined one cycle: visible the cycle after the commit.
    - last_reg and last_data update every edge; they are meaningful only when last_we = 1.
  - If wb_valid: retire_count <= retire_count + 1, counted regardless of WB_regwrite.
    - Wraps modulo 2**CNT_W (all-ones + 1 = 0); no saturation, no flag.
- Register 0:
  - Never written.
  - Writes to index 0 are dropped; last_we = 0 for them, retire_count still increments.
  - Reads of index 0 always return 0.
- Reads are asynchronous:
  - rs_data = (rs_addr == 0) ? 0 : regs[rs_addr]; same for rt.
  - Read-during-write ordering is governed by the optional feature below.
- Bubble (wb_valid = 0): no register write; last_we <= 0; counter holds.
- No stall or backpressure input: the stage retires one slot per cycle unconditionally.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined (write-through bypass):
  - If commit is asserted and rs_addr == WB_writereg, rs_data = wb_data in the same cycle; likewise for rt.
  - This removes the structural hazard of a same-cycle ID read.
- Not defined:
  - Reads return the stored value only.
  - The new value is visible on the read ports from the cycle after the commit edge.
  - The hazard unit must then stall one extra cycle.
- The bypass never applies to index 0.

Test Plan:
- Reset behaviour: hold rst_n = 0, pulse clk, release; read r1..r31 -> all 0, retire_count = 0, last_we = 0. Assert rst_n mid-cycle while commit = 1 -> target register stays 0.
- Source select: ALU write, then load write.
  - wb_valid = 1, regwrite = 1, writereg = 5, memtoreg = 0, aluresult = 0x0000_1234 -> after the edge, rs_addr = 5 gives 0x0000_1234; last_we = 1, last_reg = 5, last_data = 0x1234.
  - Then memtoreg = 1, memread = 0xDEAD_BEEF, writereg = 7 -> r7 = 0xDEADBEEF.
- r0 and no-write slots: writereg = 0, data 0xFFFF_FFFF -> r0 reads 0, last_we = 0, retire_count += 1. Separately, regwrite = 0 with writereg = 3 -> r3 unchanged, counter += 1.
- Bubble: wb_valid = 0, regwrite = 1, writereg = 4 -> no write; counter unchanged; last_we = 0 the following cycle.
- Same-cycle read of the register being written: commit writereg = 9 with data 0xA5A5_A5A5 while rs_addr = rt_addr = 9 (old r9 = 0x1).
  - With WB_BYPASS_EN: rs_data = rt_data = 0xA5A5A5A5 before the edge.
  - Without it: 0x1 before the edge, 0xA5A5A5A5 after.
- Counter wrap: build with CNT_W = 4; drive 17 consecutive valid slots -> retire_count sequence passes 15 -> 0 and ends at 1.
